bottle_fill_ctrl: RTL and testbench

Sequencing controller for the pill-bottling line. Issues one pill-drop pulse per pill until the current bottle reaches its configured pill count, then drives the conveyor to bring the next bottle, counting completed bottles until a target is reached. Produces the BCD pill count, the BCD bottle count and the all-full flag consumed by the display and counting logic.

---
 rtl/bottle_pkg.sv | 42 ++++
 rtl/bottle_fill_ctrl_bcd2_counter.sv | 34 +++
 rtl/bottle_fill_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_bottle_fill_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bottle_pkg.sv
// Shared types and BCD helpers for the pill-bottling sequencer.
package bottle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISPENSE,
    ST_GAP,
    ST_ADVANCE,
    ST_DONE,
    ST_ERR
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX_DIGIT = 4'd9;
  localparam int   CNT_W         = 16;

  // Two-digit BCD increment; holds at 99 so the count can never leave BCD range.
  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    bcd_t lo;
    bcd_t hi;
    lo = v[3:0];
    hi = v[7:4];
    if (lo == BCD_MAX_DIGIT && hi == BCD_MAX_DIGIT) begin
      return v;
    end
    if (lo >= BCD_MAX_DIGIT) begin
      lo = 4'd0;
      hi = hi + 4'd1;
    end else begin
      lo = lo + 4'd1;
    end
    return {hi, lo};
  endfunction

  function automatic logic cfg_valid(input logic [7:0] max_v, input logic [7:0] tgt_v);
    return (max_v[3:0] <= BCD_MAX_DIGIT) && (max_v[7:4] <= BCD_MAX_DIGIT) &&
           (tgt_v[3:0] <= BCD_MAX_DIGIT) && (tgt_v[7:4] <= BCD_MAX_DIGIT) &&
           (max_v != 8'h00) && (tgt_v != 8'h00);
  endfunction

endpackage

// File: rtl/bottle_fill_ctrl_bcd2_counter.sv
// Two-digit BCD counter with synchronous clear (clear wins over increment).
module bcd2_counter
  import bottle_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [7:0] val_o
);

  logic [7:0] val_q;
  logic [7:0] val_d;

  always_comb begin
    val_d = val_q;
    if (clr_i) begin
      val_d = 8'h00;
    end else if (inc_i) begin
      val_d = bcd2_inc(val_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      val_q <= 8'h00;
    end else begin
      val_q <= val_d;
    end
  end

  assign val_o = val_q;

endmodule

// File: rtl/bottle_fill_ctrl.sv
// Pill-bottling sequencer: drops pills into a bottle up to a BCD count, then
// advances the conveyor, repeating until the target number of bottles is filled.
//
// state    | meaning
// IDLE     | waiting for start; EN_set clears counts
// DISPENSE | one-cycle pill drop strobe
// GAP      | idle spacing between consecutive pills
// ADVANCE  | conveyor driven to bring the next bottle
// DONE     | run complete, allFull asserted
// ERR      | invalid configuration, waits for EN_set
module bottle_fill_ctrl
  import bottle_pkg::*;
#(
  parameter int PILL_GAP    = 4,
  parameter int MOVE_CYCLES = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       isWork,
  input  logic       EN_set,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] maxL,
  input  logic [3:0] maxH,
  input  logic [3:0] tgtL,
  input  logic [3:0] tgtH,
  output logic       pill_drop,
  output logic       conveyor_move,
  output logic [3:0] nowL,
  output logic [3:0] nowH,
  output logic [3:0] seqL,
  output logic [3:0] seqH,
  output logic       allFull,
  output logic       err
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       max_q;
  logic [7:0]       tgt_q;
  logic             pill_drop_q;
  logic             move_q;
  logic             full_q;
  logic             err_q;

  logic [7:0] pill_val;
  logic [7:0] seq_val;
  logic [7:0] pill_next;
  logic [7:0] seq_next;
  logic       run;
  logic       cnt_zero;
  logic       cfg_ok;
  logic       cnt_clear;
  logic       pill_clr;
  logic       pill_inc;
  logic       seq_clr;
  logic       seq_inc;

  // Count strobes are gated by run so that pause and !isWork leave counts untouched.
  always_comb begin
    run       = isWork && !pause;
    cnt_zero  = (cnt_q == '0);
    cfg_ok    = cfg_valid({maxH, maxL}, {tgtH, tgtL});
    pill_next = bcd2_inc(pill_val);
    seq_next  = bcd2_inc(seq_val);
    cnt_clear = 1'b0;
    if (state_q == ST_IDLE || state_q == ST_DONE) begin
      cnt_clear = EN_set || (start && cfg_ok);
    end else if (state_q == ST_ERR) begin
      cnt_clear = EN_set;
    end
    pill_clr = run && (cnt_clear || (state_q == ST_ADVANCE && cnt_zero));
    pill_inc = run && (state_q == ST_DISPENSE);
    seq_clr  = run && cnt_clear;
    seq_inc  = run && (state_q == ST_ADVANCE) && cnt_zero;
  end

  bcd2_counter u_pill_cnt (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .clr_i  (pill_clr),
    .inc_i  (pill_inc),
    .val_o  (pill_val)
  );

  bcd2_counter u_seq_cnt (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .clr_i  (seq_clr),
    .inc_i  (seq_inc),
    .val_o  (seq_val)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      max_q       <= 8'h00;
      tgt_q       <= 8'h00;
      pill_drop_q <= 1'b0;
      move_q      <= 1'b0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
    end else if (!isWork) begin
      state_q     <= ST_IDLE;
      pill_drop_q <= 1'b0;
      move_q      <= 1'b0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
    end else if (pause) begin
      pill_drop_q <= 1'b0;
      move_q      <= 1'b0;
    end else begin
      pill_drop_q <= 1'b0;
      move_q      <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (EN_set) begin
            state_q <= ST_IDLE;
            full_q  <= 1'b0;
          end else if (start) begin
            max_q  <= {maxH, maxL};
            tgt_q  <= {tgtH, tgtL};
            full_q <= 1'b0;
            if (cfg_ok) begin
              state_q     <= ST_DISPENSE;
              pill_drop_q <= 1'b1;
            end else begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        ST_DISPENSE: begin
          if (pill_next == max_q) begin
            state_q <= ST_ADVANCE;
            cnt_q   <= CNT_W'(MOVE_CYCLES - 1);
            move_q  <= 1'b1;
          end else begin
            state_q <= ST_GAP;
            cnt_q   <= CNT_W'(PILL_GAP - 1);
          end
        end
        ST_GAP: begin
          if (cnt_zero) begin
            state_q     <= ST_DISPENSE;
            pill_drop_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_ADVANCE: begin
          if (cnt_zero) begin
            if (seq_next == tgt_q) begin
              state_q <= ST_DONE;
              full_q  <= 1'b1;
            end else begin
              state_q     <= ST_DISPENSE;
              pill_drop_q <= 1'b1;
            end
          end else begin
            cnt_q  <= cnt_q - 1'b1;
            move_q <= 1'b1;
          end
        end
        ST_ERR: begin
          if (EN_set) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign pill_drop     = pill_drop_q;
  assign conveyor_move = move_q;
  assign allFull       = full_q;
  assign err           = err_q;
  assign nowL          = pill_val[3:0];
  assign nowH          = pill_val[7:4];
  assign seqL          = seq_val[3:0];
  assign seqH          = seq_val[7:4];

endmodule

// File: tb/tb_bottle_fill_ctrl.sv
// Directed bench for bottle_fill_ctrl with a queue of expected pill-drop cycles.
module tb_bottle_fill_ctrl;

  localparam int G = 4;
  localparam int M = 8;

  logic       CLK    = 1'b0;
  logic       RST_N  = 1'b0;
  logic       isWork = 1'b0;
  logic       EN_set = 1'b0;
  logic       start  = 1'b0;
  logic       pause  = 1'b0;
  logic [3:0] maxL   = 4'd0;
  logic [3:0] maxH   = 4'd0;
  logic [3:0] tgtL   = 4'd0;
  logic [3:0] tgtH   = 4'd0;
  logic       pill_drop;
  logic       conveyor_move;
  logic [3:0] nowL;
  logic [3:0] nowH;
  logic [3:0] seqL;
  logic [3:0] seqH;
  logic       allFull;
  logic       err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q[$];

  bottle_fill_ctrl #(.PILL_GAP(G), .MOVE_CYCLES(M)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .isWork        (isWork),
    .EN_set        (EN_set),
    .start         (start),
    .pause         (pause),
    .maxL          (maxL),
    .maxH          (maxH),
    .tgtL          (tgtL),
    .tgtH          (tgtH),
    .pill_drop     (pill_drop),
    .conveyor_move (conveyor_move),
    .nowL          (nowL),
    .nowH          (nowH),
    .seqL          (seqL),
    .seqH          (seqH),
    .allFull       (allFull),
    .err           (err)
  );

  always #5 CLK = ~CLK;

  function automatic int to_bcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic set_cfg(input int mx, input int tg);
    maxL = 4'(mx % 10);
    maxH = 4'(mx / 10);
    tgtL = 4'(tg % 10);
    tgtH = 4'(tg / 10);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    cyc = 1;
  endtask

  // Full run from IDLE/DONE; a pause window of p_len cycles begins at cycle p_at.
  task automatic run_bottles(input int mx, input int tg, input int p_at, input int p_len,
                             input string tag);
    int per;
    int done_exp;
    int drops;
    int conv_cnt;
    bit prev_drop;
    per      = mx * (1 + G) - G + M;
    done_exp = tg * per + 1 + p_len;
    drops    = 0;
    conv_cnt = 0;
    prev_drop = 1'b0;
    exp_q.delete();
    if (p_len == 0) begin
      for (int b = 0; b < tg; b++) begin
        for (int p = 0; p < mx; p++) begin
          exp_q.push_back(1 + b * per + p * (1 + G));
        end
      end
    end
    set_cfg(mx, tg);
    do_start();
    chk({tag, "_full_clr"}, int'(allFull), 0);
    while (!allFull && cyc < 5000) begin
      if (prev_drop) begin
        chk({tag, "_now_inc"}, int'({nowH, nowL}), to_bcd(((drops - 1) % mx) + 1));
      end
      prev_drop = pill_drop;
      if (pill_drop) begin
        drops++;
        if (exp_q.size() > 0) begin
          chk({tag, "_drop_cyc"}, cyc, exp_q.pop_front());
        end else if (p_len == 0) begin
          chk({tag, "_extra_drop"}, cyc, -1);
        end
      end
      if (conveyor_move) conv_cnt++;
      pause = (cyc >= p_at && cyc < p_at + p_len);
      tick();
    end
    pause = 1'b0;
    chk({tag, "_done_cyc"}, cyc, done_exp);
    chk({tag, "_drops"}, drops, mx * tg);
    chk({tag, "_seq"}, int'({seqH, seqL}), to_bcd(tg));
    chk({tag, "_now"}, int'({nowH, nowL}), 0);
    if (p_len == 0) begin
      chk({tag, "_conv_cycles"}, conv_cnt, M * tg);
    end
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst_pill_drop", int'(pill_drop), 0);
    chk("rst_conv", int'(conveyor_move), 0);
    chk("rst_allfull", int'(allFull), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_now", int'({nowH, nowL}), 0);
    chk("rst_seq", int'({seqH, seqL}), 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N  = 1'b1;
    isWork = 1'b1;

    // Invalid digit in max
    maxL = 4'hA; maxH = 4'h0; tgtL = 4'h2; tgtH = 4'h0;
    do_start();
    chk("errA_err", int'(err), 1);
    for (int i = 0; i < 4; i++) begin
      chk("errA_no_drop", int'(pill_drop), 0);
      tick();
    end
    EN_set = 1'b1;
    tick();
    EN_set = 1'b0;
    chk("errA_clear", int'(err), 0);

    // Zero target
    set_cfg(3, 0);
    do_start();
    chk("errT_err", int'(err), 1);
    chk("errT_no_drop", int'(pill_drop), 0);
    EN_set = 1'b1;
    tick();
    EN_set = 1'b0;
    chk("errT_clear", int'(err), 0);

    // Main timing run, then restart from DONE for the rest
    run_bottles(3, 2, 0, 0, "run32");
    run_bottles(12, 1, 0, 0, "run12");
    run_bottles(3, 2, 3, 5, "pgap");
    run_bottles(3, 2, 14, 5, "padv");

    // isWork dropped during the second bottle's conveyor advance
    set_cfg(3, 2);
    do_start();
    while (cyc < 33) tick();
    chk("iw_conv_before", int'(conveyor_move), 1);
    chk("iw_seq_before", int'({seqH, seqL}), 8'h01);
    isWork = 1'b0;
    tick();
    chk("iw_conv_off", int'(conveyor_move), 0);
    chk("iw_seq_kept", int'({seqH, seqL}), 8'h01);
    chk("iw_now_kept", int'({nowH, nowL}), 8'h03);
    repeat (3) tick();
    chk("iw_no_drop", int'(pill_drop), 0);
    chk("iw_no_full", int'(allFull), 0);
    isWork = 1'b1;
    EN_set = 1'b1;
    tick();
    EN_set = 1'b0;
    chk("iw_seq_clr", int'({seqH, seqL}), 0);
    chk("iw_now_clr", int'({nowH, nowL}), 0);

    // Asynchronous reset during the second DISPENSE of a run
    set_cfg(3, 2);
    do_start();
    while (cyc < 6) tick();
    chk("ar_drop_before", int'(pill_drop), 1);
    chk("ar_now_before", int'({nowH, nowL}), 8'h01);
    RST_N = 1'b0;
    #1;
    chk("ar_drop", int'(pill_drop), 0);
    chk("ar_now", int'({nowH, nowL}), 0);
    chk("ar_seq", int'({seqH, seqL}), 0);
    chk("ar_conv", int'(conveyor_move), 0);
    chk("ar_full", int'(allFull), 0);
    chk("ar_err", int'(err), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("ar_idle_no_drop", int'(pill_drop), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
